// File: rtl/contador_pkg.sv
// Shared definitions for the adjustable date/time field counter:
// repeat FSM encodings, step direction constants and elaboration helpers.
package contador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Ceiling log2, used to size the repeat timers at elaboration time.
  function automatic int clog2(input longint v);
    int r;
    r = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Number of decimal digits needed to show a value.
  function automatic int num_digits(input int unsigned v);
    int          d;
    int unsigned x;
    d = 1;
    x = v;
    for (int i = 0; i < 10; i++) begin
      if (x >= 10) begin
        x = x / 10;
        d = d + 1;
      end
    end
    return d;
  endfunction

  // Packed BCD of a constant (up to 8 digits), used for reset values.
  function automatic logic [31:0] bin2bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_ajuste_mod_repetidor_boton.sv
// Button front end for the adjustable counter: registers the debounced
// buttons, detects presses and runs the hold/auto-repeat FSM, emitting
// single-cycle step_up / step_down pulses.
module repetidor_boton
  import contador_pkg::*;
#(
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic boton_aumenta,
  input  logic boton_disminuye,
  output logic step_up,
  output logic step_down
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = (clog2(TMAX) < 1) ? 1 : clog2(TMAX);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

  // Bit 0 is the up button, bit 1 the down button.
  logic [1:0]    btn_q, btn_d, btn_prev_q, btn_prev_d, armed_q, armed_d;
  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic [TW-1:0] delay_cnt_q, delay_cnt_d, rate_cnt_q, rate_cnt_d;
  logic          step, step_dir;
  logic [1:0]    rise;
  logic          press_up, press_dn, latched_btn, abort;

  // State, timers and button sample registers; reset aborts any hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q       <= 2'b00;
      btn_prev_q  <= 2'b00;
      armed_q     <= 2'b00;
      state_q     <= ST_IDLE;
      dir_q       <= DIR_UP;
      delay_cnt_q <= '0;
      rate_cnt_q  <= '0;
    end else begin
      btn_q       <= btn_d;
      btn_prev_q  <= btn_prev_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      dir_q       <= dir_d;
      delay_cnt_q <= delay_cnt_d;
      rate_cnt_q  <= rate_cnt_d;
    end
  end

  // Press detection and repeat FSM; a button held through reset stays
  // disarmed until it has been seen released, so it cannot step on its own.
  always_comb begin
    btn_d       = {boton_disminuye, boton_aumenta};
    btn_prev_d  = btn_q;
    armed_d     = armed_q | ~{boton_disminuye, boton_aumenta};
    state_d     = state_q;
    dir_d       = dir_q;
    delay_cnt_d = delay_cnt_q;
    rate_cnt_d  = rate_cnt_q;
    step        = 1'b0;
    step_dir    = dir_q;

    rise        = btn_q & ~btn_prev_q & armed_q;
    press_up    = rise[0] & ~btn_q[1];
    press_dn    = rise[1] & ~btn_q[0];
    latched_btn = (dir_q == DIR_UP) ? btn_q[0] : btn_q[1];
    abort       = ~latched_btn | (&btn_q);

    case (state_q)
      ST_IDLE: begin
        delay_cnt_d = '0;
        rate_cnt_d  = '0;
        if (press_up) begin
          step     = 1'b1;
          step_dir = DIR_UP;
          dir_d    = DIR_UP;
          state_d  = ST_DELAY;
        end else if (press_dn) begin
          step     = 1'b1;
          step_dir = DIR_DOWN;
          dir_d    = DIR_DOWN;
          state_d  = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (abort) begin
          state_d     = ST_IDLE;
          delay_cnt_d = '0;
        end else if (delay_cnt_q == DELAY_LAST) begin
          step        = 1'b1;
          state_d     = ST_REPEAT;
          delay_cnt_d = '0;
          rate_cnt_d  = '0;
        end else begin
          delay_cnt_d = delay_cnt_q + TW'(1);
        end
      end
      ST_REPEAT: begin
        if (abort) begin
          state_d    = ST_IDLE;
          rate_cnt_d = '0;
        end else if (rate_cnt_q == RATE_LAST) begin
          step       = 1'b1;
          rate_cnt_d = '0;
        end else begin
          rate_cnt_d = rate_cnt_q + TW'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        delay_cnt_d = '0;
        rate_cnt_d  = '0;
      end
    endcase

    step_up   = step & (step_dir == DIR_UP);
    step_down = step & (step_dir == DIR_DOWN);
  end

endmodule

// File: rtl/contador_ajuste_mod.sv
// Up/down modulo counter for an adjustable date/time field with button
// stepping and auto-repeat, synchronous load, cascade increment and carry.
// Optional registered BCD output when CONTADOR_BCD_EN is defined.
module contador_ajuste_mod
  import contador_pkg::*;
#(
  parameter int WIDTH        = 7,
  parameter int MIN_VAL      = 0,
  parameter int MAX_VAL      = 99,
  parameter int RESET_VAL    = MIN_VAL,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             boton_aumenta,
  input  logic             boton_disminuye,
  input  logic             inc_in,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] countyears,
  output logic             carry_out
`ifdef CONTADOR_BCD_EN
  ,
  output logic [4*num_digits(MAX_VAL)-1:0] countyears_bcd
`endif
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d, up_val, down_val;
  logic [WIDTH:0]   load_plus1;
  logic             load_ok;
  logic             carry_q, carry_d;
  logic             step_up, step_down;

  repetidor_boton #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_repetidor (
    .clk             (clk),
    .reset           (reset),
    .boton_aumenta   (boton_aumenta),
    .boton_disminuye (boton_disminuye),
    .step_up         (step_up),
    .step_down       (step_down)
  );

  // Next count by priority: load, then button step, then cascade increment.
  always_comb begin
    count_d    = count_q;
    carry_d    = 1'b0;
    up_val     = (count_q == MAX_W) ? MIN_W : count_q + WIDTH'(1);
    down_val   = (count_q == MIN_W) ? MAX_W : count_q - WIDTH'(1);
    load_plus1 = {1'b0, load_val} + (WIDTH+1)'(1);
    load_ok    = (load_plus1 > (WIDTH+1)'(MIN_VAL)) && (load_val <= MAX_W);
    if (load_en) begin
      count_d = load_ok ? load_val : MIN_W;
    end else if (step_up) begin
      count_d = up_val;
    end else if (step_down) begin
      count_d = down_val;
    end else if (inc_in) begin
      count_d = up_val;
      carry_d = (count_q == MAX_W);
    end
  end

  // Count and carry registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RST_W;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  assign countyears = count_q;
  assign carry_out  = carry_q;

`ifdef CONTADOR_BCD_EN
  localparam int          DIG      = num_digits(MAX_VAL);
  localparam logic [31:0] BCD_RST  = bin2bcd(RESET_VAL);

  logic [4*DIG-1:0] bcd_q, bcd_d;

  // Double-dabble conversion of the current count.
  always_comb begin
    bcd_d = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      for (int d = 0; d < DIG; d++) begin
        if (bcd_d[4*d +: 4] >= 4'd5) bcd_d[4*d +: 4] = bcd_d[4*d +: 4] + 4'd3;
      end
      bcd_d = {bcd_d[4*DIG-2:0], count_q[i]};
    end
  end

  // BCD register, one cycle behind the binary count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bcd_q <= BCD_RST[4*DIG-1:0];
    else       bcd_q <= bcd_d;
  end

  assign countyears_bcd = bcd_q;
`endif

endmodule

// File: tb/tb_contador_ajuste_mod.sv
// Bench for contador_ajuste_mod: directed scenarios followed by random
// holds, loads and cascade increments against an arithmetic model.
module tb_contador_ajuste_mod;

  localparam int D = 8;
  localparam int R = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       up_a = 1'b0, dn_a = 1'b0, inc_a = 1'b0, load_en_a = 1'b0;
  logic [6:0] load_val_a = '0;
  logic [6:0] count_a;
  logic       carry_a;
  logic       up_b = 1'b0, dn_b = 1'b0;
  logic [3:0] count_b;
  logic       carry_b;
`ifdef CONTADOR_BCD_EN
  logic [7:0] bcd_a;
  logic [7:0] bcd_b;
`endif

  int checks = 0;
  int errors = 0;
  int exp_a = 0;
  int carry_pulses = 0;

  always #5 clk = ~clk;

  contador_ajuste_mod #(
    .WIDTH(7), .MIN_VAL(0), .MAX_VAL(99), .RESET_VAL(0),
    .REPEAT_DELAY(D), .REPEAT_RATE(R)
  ) dut_a (
    .clk(clk), .reset(reset),
    .boton_aumenta(up_a), .boton_disminuye(dn_a),
    .inc_in(inc_a), .load_en(load_en_a), .load_val(load_val_a),
    .countyears(count_a), .carry_out(carry_a)
`ifdef CONTADOR_BCD_EN
    , .countyears_bcd(bcd_a)
`endif
  );

  contador_ajuste_mod #(
    .WIDTH(4), .MIN_VAL(1), .MAX_VAL(12), .RESET_VAL(1),
    .REPEAT_DELAY(D), .REPEAT_RATE(R)
  ) dut_b (
    .clk(clk), .reset(reset),
    .boton_aumenta(up_b), .boton_disminuye(dn_b),
    .inc_in(1'b0), .load_en(1'b0), .load_val(4'd0),
    .countyears(count_b), .carry_out(carry_b)
`ifdef CONTADOR_BCD_EN
    , .countyears_bcd(bcd_b)
`endif
  );

  // Counts carry pulses seen on the 0..99 instance.
  always @(negedge clk) if (carry_a === 1'b1) carry_pulses++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Value after n modular steps in [mn, mx].
  function automatic int wrapStep(input int v, input int n, input bit up, input int mn, input int mx);
    int span, off;
    span = mx - mn + 1;
    off  = v - mn;
    if (up) off = (off + n) % span;
    else    off = (((off - n) % span) + span) % span;
    return mn + off;
  endfunction

  // Steps landed by offset o after the first high sample of a hold lasting
  // len samples: offset 1, then 1+D, then every R cycles, while o <= len.
  function automatic int nSteps(input int o, input int len);
    int m;
    m = (o < len) ? o : len;
    if (m < 1) return 0;
    if (m < 1 + D) return 1;
    return 2 + (m - 1 - D) / R;
  endfunction

  task automatic applyStimulus(input logic ld, input logic [6:0] val, input logic inc);
    load_en_a  = ld;
    load_val_a = val;
    inc_a      = inc;
  endtask

  // Hold one button for len samples; if both_end, the other button is
  // raised instead of releasing, then both drop a few cycles later.
  task automatic holdButton(input bit up, input int len, input bit both_end, input string tag);
    int start, pulses0;
    start   = exp_a;
    pulses0 = carry_pulses;
    if (up) up_a = 1'b1; else dn_a = 1'b1;
    for (int o = 0; o < len + 4; o++) begin
      @(negedge clk);
      checkOutput(tag, 32'(count_a), 32'(wrapStep(start, nSteps(o, len), up, 0, 99)));
      if (o == len - 1) begin
        if (both_end) begin up_a = 1'b1; dn_a = 1'b1; end
        else          begin up_a = 1'b0; dn_a = 1'b0; end
      end
    end
    up_a = 1'b0;
    dn_a = 1'b0;
    repeat (3) @(negedge clk);
    exp_a = wrapStep(start, nSteps(len, len), up, 0, 99);
    checkOutput({tag, "_final"}, 32'(count_a), 32'(exp_a));
    checkOutput({tag, "_nocarry"}, 32'(carry_pulses - pulses0), 32'd0);
  endtask

  task automatic loadValue(input int v, input bit with_inc, input string tag);
    applyStimulus(1'b1, 7'(v), with_inc);
    @(negedge clk);
    applyStimulus(1'b0, 7'd0, 1'b0);
    exp_a = (v >= 0 && v <= 99) ? v : 0;
    checkOutput(tag, 32'(count_a), 32'(exp_a));
    checkOutput({tag, "_carry"}, 32'(carry_a), 32'd0);
  endtask

  task automatic pulseInc(input string tag);
    bit wraps;
    wraps = (exp_a == 99);
    applyStimulus(1'b0, 7'd0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 7'd0, 1'b0);
    exp_a = wrapStep(exp_a, 1, 1'b1, 0, 99);
    checkOutput(tag, 32'(count_a), 32'(exp_a));
    checkOutput({tag, "_carry"}, 32'(carry_a), 32'(wraps));
    @(negedge clk);
    checkOutput({tag, "_carry_end"}, 32'(carry_a), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_count_a", 32'(count_a), 32'd0);
    checkOutput("rst_carry_a", 32'(carry_a), 32'd0);
    checkOutput("rst_count_b", 32'(count_b), 32'd1);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single presses across the wrap points
    loadValue(98, 1'b0, "load_98");
    holdButton(1'b1, 1, 1'b0, "up_98");
    holdButton(1'b1, 1, 1'b0, "up_99_wrap");
    holdButton(1'b0, 1, 1'b0, "dn_0_wrap");

    // Narrow range instance: down from MIN_VAL wraps to MAX_VAL
    dn_b = 1'b1;
    @(negedge clk);
    dn_b = 1'b0;
    checkOutput("b_before_step", 32'(count_b), 32'd1);
    @(negedge clk);
    checkOutput("b_dn_1_wrap", 32'(count_b), 32'd12);
    repeat (3) @(negedge clk);
    up_b = 1'b1;
    @(negedge clk);
    up_b = 1'b0;
    @(negedge clk);
    checkOutput("b_up_12_wrap", 32'(count_b), 32'd1);
    checkOutput("b_carry", 32'(carry_b), 32'd0);

    // Auto-repeat timing: steps at k+1, k+9, k+12, k+15
    loadValue(5, 1'b0, "load_5");
    holdButton(1'b1, 15, 1'b0, "hold_up");

    // Both buttons together never step
    loadValue(40, 1'b0, "load_40");
    up_a = 1'b1;
    dn_a = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("both_held", 32'(count_a), 32'd40);
    up_a = 1'b0;
    dn_a = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("both_released", 32'(count_a), 32'd40);

    // Raising down while repeating up stops stepping
    loadValue(20, 1'b0, "load_20");
    holdButton(1'b1, 10, 1'b1, "up_then_both");

    // Cascade increment, priority against load, out-of-range load
    loadValue(99, 1'b0, "load_99");
    pulseInc("inc_wrap");
    loadValue(99, 1'b0, "load_99b");
    loadValue(50, 1'b1, "load_over_inc");
    loadValue(120, 1'b0, "load_out_of_range");

    // Asynchronous reset in the middle of a repeat
    loadValue(30, 1'b0, "load_30");
    up_a = 1'b1;
    repeat (14) @(negedge clk);
    checkOutput("pre_reset_repeat", 32'(count_a), 32'(wrapStep(30, nSteps(13, 100), 1'b1, 0, 99)));
    reset = 1'b1;
    #1;
    checkOutput("async_reset_count", 32'(count_a), 32'd0);
    checkOutput("async_reset_carry", 32'(carry_a), 32'd0);
    exp_a = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("held_after_reset", 32'(count_a), 32'd0);
    up_a = 1'b0;
    repeat (3) @(negedge clk);
    holdButton(1'b1, 1, 1'b0, "repress_after_reset");

`ifdef CONTADOR_BCD_EN
    loadValue(73, 1'b0, "load_73");
    @(negedge clk);
    checkOutput("bcd_73", 32'(bcd_a), 32'h73);
`endif

    // Random mix of holds, loads and cascade increments
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: holdButton(1'($urandom_range(0, 1)), int'($urandom_range(1, 20)),
                      1'($urandom_range(0, 1)), "rand_hold");
        1: loadValue(int'($urandom_range(0, 127)), 1'b0, "rand_load");
        default: pulseInc("rand_inc");
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_ajuste_mod.md
# contador_ajuste_mod

Parametrised up/down modulo counter for user-adjustable date and time fields such as year, month, day, hour and minute. It replaces the fixed 0..99 year counter with configurable width and range, single-step stepping on button press edges, and auto-repeat while a button is held. It also adds a synchronous load, a cascade increment input and a wrap carry output. It sits between the debounced front-panel buttons and the display and clock-calendar logic.

## Interface
- WIDTH, 7: counter width in bits.
- MIN_VAL, 0: lowest count value.
- MAX_VAL, 99: highest count value. Must satisfy MIN_VAL < MAX_VAL < 2**WIDTH.
- RESET_VAL, MIN_VAL: count value after reset.
- REPEAT_DELAY, 50_000_000: hold cycles after the first step before auto-repeat starts.
- REPEAT_RATE, 10_000_000: cycles between auto-repeat steps.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- boton_aumenta  in  1  debounced up button, level.
- boton_disminuye  in  1  debounced down button, level.
- inc_in  in  1  single-cycle cascade increment from the lower-order field.
- load_en  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- countyears  out  WIDTH  registered count.
- carry_out  out  1  one-cycle pulse on an inc_in wrap from MAX_VAL to MIN_VAL.

## Operation
- Buttons are registered once into btn_q. The previous sample is kept in btn_prev.
- A press is a rising edge of btn_q for exactly one button while the other btn_q is low.
- Repeat FSM states:
  - IDLE: on a press, generate one step, latch the direction and go to DELAY.
  - DELAY: count REPEAT_DELAY cycles. On expiry, generate a step and go to REPEAT.
  - REPEAT: generate a step every REPEAT_RATE cycles.
  - From DELAY or REPEAT, go to IDLE when the latched button is released or both buttons are high. No step is generated on that cycle.
- Both buttons rising on the same cycle: no step, and the FSM stays in IDLE.
- Step arithmetic:
  - Up: MAX_VAL wraps to MIN_VAL, otherwise +1.
  - Down: MIN_VAL wraps to MAX_VAL, otherwise -1.
  - Arithmetic is in WIDTH bits and never leaves [MIN_VAL, MAX_VAL].
- Per-cycle priority, highest first: load_en, then button step, then inc_in. A lower-priority event on the same cycle is dropped.
- Load: load_val inside [MIN_VAL, MAX_VAL] is loaded as given. Out-of-range values load MIN_VAL. Load does not change the FSM state.
- inc_in performs an up step. carry_out is asserted only when that step wraps. Button wraps never assert carry_out.

## Timing
- Reset values: countyears = RESET_VAL, carry_out = 0, FSM = IDLE, both timers = 0, btn_q = btn_prev = 0.
- Button latency:
  - Edge k is the first rising edge that samples the button high.
  - countyears changes at edge k+1.
  - The first repeat step lands REPEAT_DELAY cycles after that.
  - Later repeat steps land every REPEAT_RATE cycles.
- Load and inc_in sampled at edge k update countyears at edge k. carry_out is high for the cycle after edge k.
- Reset asserted mid-hold or mid-repeat aborts immediately. After release, a still-held button needs a new rising edge before it steps.
- Timer counters are clog2-sized from the larger of REPEAT_DELAY and REPEAT_RATE.

## Configuration
- CONTADOR_BCD_EN defined:
  - Adds output countyears_bcd, 4*D bits, where D is the number of decimal digits of MAX_VAL.
  - The output is registered and trails countyears by one cycle.
  - Reset value is the BCD of RESET_VAL.
- CONTADOR_BCD_EN undefined: the port and its logic do not exist.

## Structure
- contador_pkg holds:
  - FSM state encodings: ST_IDLE=2'd0, ST_DELAY=2'd1, ST_REPEAT=2'd2.
  - Direction constants DIR_UP and DIR_DOWN.
  - A clog2 function.
- Sub-module repetidor_boton contains the button registers, edge detect, FSM and timers. It outputs step_up and step_down pulses.
- Binary-to-BCD conversion is inline combinational double-dabble under the macro.

## Test plan
- Reset, then press boton_aumenta for 1 cycle at count 98 -> 99. Press again -> 0, with carry_out staying 0.
- At count 0, press boton_disminuye -> 99. With MIN_VAL=1 and MAX_VAL=12, down from 1 -> 12.
- Hold up with REPEAT_DELAY=8 and REPEAT_RATE=3 from 5:
  - Steps land at edges k+1, k+9, k+12 and k+15.
  - Release -> no further steps.
- Assert both buttons simultaneously at count 40 -> stays 40. While holding up in REPEAT, raise down -> stepping stops at the current value.
- With inc_in pulsed at 99, expect 0 and one carry_out pulse.
  - Same cycle as load_en with load_val=50 -> 50, no carry.
  - load_val=120 -> MIN_VAL.
- Assert reset asynchronously mid-REPEAT -> countyears = RESET_VAL immediately. A held button does not step until it is released and pressed again.
- With CONTADOR_BCD_EN defined, count 73 -> countyears_bcd = 8'h73 one cycle later.
